// File: rtl/barrel_shift_arbiter.sv
// barrel_shift_arbiter
// Two-requester round-robin arbiter in front of one shared 8-bit rotator.
// The granted operand passes through a 2:1 mux into a single combinational
// rotator. The result is registered, tagged with the requester ID, and held
// until downstream accepts it.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   reqN_valid/_a/_amt/_lr       requester N operation (lr=1 rotates right)
//   reqN_ready                   requester N accepted this cycle
//   out_valid/out_y/out_id       registered result and producing requester
//   out_ready                    downstream accepts the result
module barrel_shift_arbiter #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [2:0] req0_amt,
  input  logic       req0_lr,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [2:0] req1_amt,
  input  logic       req1_lr,
  output logic       req1_ready,
  output logic       out_valid,
  output logic [7:0] out_y,
  output logic       out_id,
  input  logic       out_ready
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_HOLD = 1'b1;

  logic       state_q, state_d;
  logic       prio_q, prio_d;
  logic [7:0] out_y_q, out_y_d;
  logic       out_id_q, out_id_d;

  logic       free;
  logic       grant0, grant1;
  logic       fire;
  logic       sel;
  logic [7:0] mux_a;
  logic [2:0] mux_amt;
  logic       mux_lr;
  logic [15:0] dbl;
  logic [15:0] dbl_sh;
  logic [7:0] rot_y;

  // The result register may load when it is empty or is being drained now.
  assign free = (state_q == ST_IDLE) | out_ready;

  // A lone valid wins outright; on contention prio picks the winner.
  assign grant0 = req0_valid & (~req1_valid | (prio_q == 1'b0));
  assign grant1 = req1_valid & (~req0_valid | (prio_q == 1'b1));

  // rst_n is folded in so no ready leaks out while reset is held.
  assign req0_ready = free & grant0 & rst_n;
  assign req1_ready = free & grant1 & rst_n;

  assign fire = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign sel  = grant1;

  // Shared operand mux: only the granted request reaches the rotator.
  always_comb begin
    mux_a   = req0_a;
    mux_amt = req0_amt;
    mux_lr  = req0_lr;
    if (sel) begin
      mux_a   = req1_a;
      mux_amt = req1_amt;
      mux_lr  = req1_lr;
    end
  end

  // Rotate by shifting a doubled copy: right takes the low half, left the high.
  always_comb begin
    dbl    = {mux_a, mux_a};
    dbl_sh = 16'h0000;
    rot_y  = 8'h00;
    if (mux_lr) begin
      dbl_sh = dbl >> mux_amt;
      rot_y  = dbl_sh[7:0];
    end else begin
      dbl_sh = dbl << mux_amt;
      rot_y  = dbl_sh[15:8];
    end
  end

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    out_y_d  = out_y_q;
    out_id_d = out_id_q;
    if (fire) begin
      state_d  = ST_HOLD;
      out_y_d  = rot_y;
      out_id_d = sel;
      prio_d   = ~sel;
    end else if (out_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prio_q   <= RR_INIT;
      out_y_q  <= 8'h00;
      out_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      out_y_q  <= out_y_d;
      out_id_q <= out_id_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_y     = out_y_q;
  assign out_id    = out_id_q;

endmodule
